// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types: status reported by the RAM port.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-side types: memory arbiter FSM states and the error load value.
package dp_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [31:0] BadWordDefault = 32'hBAD1_BAD1;

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register: remembers the last LL address until an SC or a
// conflicting store consumes it.
module llsc_link #(
  parameter int unsigned AddrW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [AddrW-1:0] set_addr_i,
  input  logic             clear_i,
  input  logic             snoop_valid_i,
  input  logic [AddrW-1:0] snoop_addr_i,
  input  logic [AddrW-1:0] check_addr_i,
  output logic             match_o
);

  logic             valid_q, valid_d;
  logic [AddrW-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = set_addr_i;
    end else if (clear_i || (snoop_valid_i && (snoop_addr_i == addr_q))) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign match_o = valid_q && (addr_q == check_addr_i);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch and data requests; data wins at IDLE,
// one transaction in flight, hits are one-cycle pulses from the RESP state.
module mem_arbiter
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int unsigned       WORD_W   = 32,
  parameter logic [WORD_W-1:0] BAD_WORD = WORD_W'(BadWordDefault)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  arb_state_t        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic [WORD_W-1:0] resp_q, resp_d;
  logic              write_q, write_d;
  logic              atomic_q, atomic_d;
  logic              dreq_q, dreq_d;

  logic link_set, link_clear, snoop_valid, link_match;

  llsc_link #(
    .AddrW(WORD_W)
  ) u_llsc_link (
    .clk_i        (CLK),
    .rst_i        (RST),
    .set_i        (link_set),
    .set_addr_i   (addr_q),
    .clear_i      (link_clear),
    .snoop_valid_i(snoop_valid),
    .snoop_addr_i (addr_q),
    .check_addr_i (daddr),
    .match_o      (link_match)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    store_d     = store_q;
    resp_d      = resp_q;
    write_d     = write_q;
    atomic_d    = atomic_q;
    dreq_d      = dreq_q;
    link_set    = 1'b0;
    link_clear  = 1'b0;
    snoop_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          addr_d   = daddr;
          store_d  = dstore;
          write_d  = dWEN;
          atomic_d = datomic;
          dreq_d   = 1'b1;
          resp_d   = '0;
          if (dWEN && datomic) begin
            // SC consumes the link either way; a miss answers without touching RAM.
            link_clear = 1'b1;
            state_d    = link_match ? DACC : RESP;
          end else begin
            state_d = DACC;
          end
        end else if (iREN) begin
          addr_d   = iaddr;
          write_d  = 1'b0;
          atomic_d = 1'b0;
          dreq_d   = 1'b0;
          state_d  = IACC;
        end
      end
      IACC, DACC: begin
        if (ramstate == ACCESS || ramstate == ERROR) begin
          state_d = RESP;
          if (ramstate == ERROR) begin
            resp_d = BAD_WORD;
          end else if (!write_q) begin
            resp_d = ramload;
          end else begin
            resp_d = {{(WORD_W - 1) {1'b0}}, atomic_q};
          end
          if (state_q == DACC) begin
            link_set    = !write_q && atomic_q;
            snoop_valid = write_q && !atomic_q;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      resp_q   <= '0;
      write_q  <= 1'b0;
      atomic_q <= 1'b0;
      dreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      resp_q   <= resp_d;
      write_q  <= write_d;
      atomic_q <= atomic_d;
      dreq_q   <= dreq_d;
    end
  end

  // Outputs decode only registered state, so ramstate never reaches the hits.
  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !write_q);
  assign ramWEN   = (state_q == DACC) && write_q;
  assign ramaddr  = (state_q == IACC || state_q == DACC) ? addr_q : '0;
  assign ramstore = ramWEN ? store_q : '0;
  assign ihit     = (state_q == RESP) && !dreq_q;
  assign dhit     = (state_q == RESP) && dreq_q;
  assign iload    = ihit ? resp_q : '0;
  assign dload    = dhit ? resp_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level memory/link model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam logic [31:0] Bad = 32'hBAD1_BAD1;
  localparam int OpFetch = 0, OpRead = 1, OpWrite = 2, OpLl = 3, OpSc = 4, OpRdWr = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, datomic = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  ramstate_t   ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .WORD_W  (32),
    .BAD_WORD(Bad)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .ihit    (ihit),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .datomic (datomic),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dhit    (dhit),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  // RAM environment: busy_cfg BUSY cycles, then ACCESS (or ERROR).
  logic [31:0] seed = 32'h0;
  bit          wr_valid [256];
  logic [31:0] wr_data  [256];
  int          acc_cnt = 0;
  int          busy_cfg = 0;
  bit          err_cfg = 1'b0;

  function automatic logic [31:0] init_word(input int idx, input logic [31:0] s);
    return s ^ (32'(idx) * 32'h9E37_79B9);
  endfunction

  always @(posedge CLK) begin
    if (ramREN || ramWEN) begin
      acc_cnt <= acc_cnt + 1;
      if (ramWEN && ramstate == ACCESS) begin
        wr_valid[ramaddr[9:2]] <= 1'b1;
        wr_data[ramaddr[9:2]]  <= ramstore;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  always_comb begin
    if (!(ramREN || ramWEN)) ramstate = FREE;
    else if (acc_cnt < busy_cfg) ramstate = BUSY;
    else if (err_cfg) ramstate = ERROR;
    else ramstate = ACCESS;
  end

  assign ramload = wr_valid[ramaddr[9:2]] ? wr_data[ramaddr[9:2]]
                                          : init_word(int'(ramaddr[9:2]), seed);

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return wr_valid[a[9:2]] ? wr_data[a[9:2]] : init_word(int'(a[9:2]), seed);
  endfunction

  // Reference model: architectural memory plus the LL link.
  logic [31:0] model_mem [256];
  bit          lv = 1'b0;
  logic [31:0] la = '0;

  task automatic model_apply(input int op, input logic [31:0] a, input logic [31:0] d,
                             input int busy, input bit err, output int exp_cyc,
                             output logic [31:0] exp_load, output int exp_wen);
    int idx = int'(a[9:2]);
    exp_cyc = busy + 2;
    exp_wen = 0;
    exp_load = '0;
    case (op)
      OpFetch, OpRead, OpLl: begin
        exp_load = err ? Bad : model_mem[idx];
        if (op == OpLl) begin
          lv = 1'b1;
          la = a;
        end
      end
      OpWrite, OpRdWr: begin
        exp_wen = busy + 1;
        model_mem[idx] = d;
        if (lv && la == a) lv = 1'b0;
      end
      default: begin
        if (lv && la == a) begin
          exp_wen = busy + 1;
          exp_load = 32'd1;
          model_mem[idx] = d;
        end else begin
          exp_cyc = 1;
        end
        lv = 1'b0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request set, drops each request on its hit, bounded at 60 cycles.
  task automatic run_txn(input bit i_en, input bit d_rd, input bit d_wr, input bit atom,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input int busy, input bit err, output int ihit_cyc, output int dhit_cyc,
                         output logic [31:0] iload_v, output logic [31:0] dload_v,
                         output int wen_n, output int ren_n, output bit bad_hit,
                         output logic [31:0] first_addr);
    bit first_seen = 1'b0;
    busy_cfg = busy;
    err_cfg = err;
    iREN = i_en; iaddr = ia;
    dREN = d_rd; dWEN = d_wr; datomic = atom; daddr = da; dstore = ds;
    ihit_cyc = -1; dhit_cyc = -1; iload_v = '0; dload_v = '0;
    wen_n = 0; ren_n = 0; bad_hit = 1'b0; first_addr = '0;
    for (int c = 0; c < 60; c++) begin
      if (ramREN) ren_n++;
      if (ramWEN) wen_n++;
      if ((ramREN || ramWEN) && !first_seen) begin
        first_seen = 1'b1;
        first_addr = ramaddr;
      end
      if ((ihit || dhit) && (ramREN || ramWEN || ramaddr != 0 || ramstore != 0)) bad_hit = 1'b1;
      if ((ihit && dhit) || (ihit && !i_en) || (dhit && !(d_rd || d_wr))) bad_hit = 1'b1;
      if (ihit && ihit_cyc < 0) begin
        ihit_cyc = c; iload_v = iload; iREN = 1'b0;
      end
      if (dhit && dhit_cyc < 0) begin
        dhit_cyc = c; dload_v = dload; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
      end
      if ((!i_en || ihit_cyc >= 0) && (!(d_rd || d_wr) || dhit_cyc >= 0)) break;
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    tick();
  endtask

  // Single data-side op; returns the hit cycle, load value and write-cycle count.
  task automatic data_op(input int op, input logic [31:0] a, input logic [31:0] d, input int busy,
                         input bit err, output int cyc, output logic [31:0] ld, output int wen,
                         output bit bad);
    int ic, ren; logic [31:0] il, fa;
    bit rd = (op == OpRead || op == OpLl || op == OpRdWr);
    bit wr = (op == OpWrite || op == OpSc || op == OpRdWr);
    bit at = (op == OpLl || op == OpSc);
    run_txn(1'b0, rd, wr, at, '0, a, d, busy, err, ic, cyc, il, ld, wen, ren, bad, fa);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {ihit, dhit, ramREN, ramWEN});
    end
    n_tests++;
    if ({iload, dload, ramaddr, ramstore} !== 128'b0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", iload, dload, ramaddr, ramstore);
    end
    RST = 1'b0;
    lv = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int ic, dc, wen, ren, ec, ew; logic [31:0] il, dl, fa, el; bit bad;
    model_apply(OpWrite, 32'h40, 32'h8C01_0004, 0, 1'b0, ec, el, ew);
    data_op(OpWrite, 32'h40, 32'h8C01_0004, 0, 1'b0, dc, dl, wen, bad);
    model_apply(OpFetch, 32'h40, '0, 0, 1'b0, ec, el, ew);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, '0, '0, 0, 1'b0, ic, dc, il, dl, wen, ren, bad, fa);
    n_tests++;
    if (ic !== 2 || il !== 32'h8C01_0004) begin
      n_fail++; $display("FAIL fetch: got cyc %0d load %h want cyc 2 load 8c010004", ic, il);
    end
    n_tests++;
    if (bad !== 1'b0 || ren !== 1 || fa !== 32'h40) begin
      n_fail++; $display("FAIL fetch_ram: got bad %0d ren %0d addr %h want 0 1 40", bad, ren, fa);
    end
  endtask

  task automatic test_priority();
    int ic, dc, wen, ren; logic [31:0] il, dl, fa; bit bad;
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, '0, 0, 1'b0, ic, dc, il, dl, wen, ren, bad, fa);
    n_tests++;
    if (dc !== 2 || ic !== 5) begin
      n_fail++; $display("FAIL priority_cycles: got dhit %0d ihit %0d want 2 5", dc, ic);
    end
    n_tests++;
    if (dl !== model_mem[64] || il !== 32'h8C01_0004) begin
      n_fail++; $display("FAIL priority_data: got %h %h want %h 8c010004", dl, il, model_mem[64]);
    end
    n_tests++;
    if (fa !== 32'h100 || ren !== 2 || wen !== 0 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_ram: got addr %h ren %0d wen %0d bad %0d want 100 2 0 0",
               fa, ren, wen, bad);
    end
  endtask

  task automatic test_busy_write();
    int dc, wen, ec, ew; logic [31:0] dl, el; bit bad;
    logic [31:0] d = $urandom;
    model_apply(OpWrite, 32'h300, d, 3, 1'b0, ec, el, ew);
    data_op(OpWrite, 32'h300, d, 3, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (wen !== 4 || dc !== 5 || dl !== 32'h0) begin
      n_fail++; $display("FAIL busy_write: got wen %0d cyc %0d load %h want 4 5 0", wen, dc, dl);
    end
    n_tests++;
    if (ram_word(32'h300) !== d) begin
      n_fail++; $display("FAIL busy_write_mem: got %h want %h", ram_word(32'h300), d);
    end
  endtask

  task automatic test_llsc();
    int dc, wen, ec, ew; logic [31:0] dl, el; bit bad;
    model_apply(OpLl, 32'h200, '0, 0, 1'b0, ec, el, ew);
    data_op(OpLl, 32'h200, '0, 0, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (dc !== 2 || dl !== el) begin
      n_fail++; $display("FAIL ll: got cyc %0d load %h want 2 %h", dc, dl, el);
    end
    model_apply(OpSc, 32'h200, 32'd7, 0, 1'b0, ec, el, ew);
    data_op(OpSc, 32'h200, 32'd7, 0, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (wen !== 1 || dl !== 32'd1 || dc !== 2 || ram_word(32'h200) !== 32'd7) begin
      n_fail++;
      $display("FAIL sc_ok: got wen %0d load %h cyc %0d mem %h want 1 1 2 7",
               wen, dl, dc, ram_word(32'h200));
    end
    model_apply(OpSc, 32'h200, 32'd9, 0, 1'b0, ec, el, ew);
    data_op(OpSc, 32'h200, 32'd9, 0, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (wen !== 0 || dl !== 32'd0 || dc !== 1 || ram_word(32'h200) !== 32'd7) begin
      n_fail++; $display("FAIL sc_again: got wen %0d load %h cyc %0d want 0 0 1", wen, dl, dc);
    end
  endtask

  task automatic test_ll_store_sc();
    int dc, wen, ec, ew; logic [31:0] dl, el; bit bad;
    model_apply(OpLl, 32'h200, '0, 0, 1'b0, ec, el, ew);
    data_op(OpLl, 32'h200, '0, 0, 1'b0, dc, dl, wen, bad);
    model_apply(OpWrite, 32'h200, 32'h55, 1, 1'b0, ec, el, ew);
    data_op(OpWrite, 32'h200, 32'h55, 1, 1'b0, dc, dl, wen, bad);
    model_apply(OpSc, 32'h200, 32'h66, 0, 1'b0, ec, el, ew);
    data_op(OpSc, 32'h200, 32'h66, 0, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (dl !== 32'd0 || wen !== 0 || dc !== 1 || ram_word(32'h200) !== 32'h55) begin
      n_fail++; $display("FAIL ll_store_sc: got load %h wen %0d cyc %0d want 0 0 1", dl, wen, dc);
    end
  endtask

  task automatic test_error();
    int dc, wen, ec, ew; logic [31:0] dl, el; bit bad;
    model_apply(OpRead, 32'h204, '0, 1, 1'b1, ec, el, ew);
    data_op(OpRead, 32'h204, '0, 1, 1'b1, dc, dl, wen, bad);
    n_tests++;
    if (dl !== 32'hBAD1_BAD1 || dc !== 3) begin
      n_fail++; $display("FAIL read_error: got load %h cyc %0d want bad1bad1 3", dl, dc);
    end
  endtask

  task automatic test_reset_mid();
    int dc, wen, ec, ew; logic [31:0] dl, el; bit bad, seen;
    model_apply(OpLl, 32'h208, '0, 0, 1'b0, ec, el, ew);
    data_op(OpLl, 32'h208, '0, 0, 1'b0, dc, dl, wen, bad);
    busy_cfg = 6; err_cfg = 1'b0;
    dREN = 1'b1; daddr = 32'h208;
    tick(); tick();
    n_tests++;
    if (ramREN !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_inflight: got ramREN %b want 1", ramREN);
    end
    RST = 1'b1; dREN = 1'b0;
    tick();
    n_tests++;
    if ({ihit, dhit, ramREN, ramWEN, iload, dload, ramaddr, ramstore} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b %h %h want all 0",
                         {ihit, dhit, ramREN, ramWEN}, dload, ramaddr);
    end
    RST = 1'b0;
    lv = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (ihit || dhit || ramREN || ramWEN) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_dropped: got activity %0d want 0", seen);
    end
    model_apply(OpSc, 32'h208, 32'h1, 0, 1'b0, ec, el, ew);
    data_op(OpSc, 32'h208, 32'h1, 0, 1'b0, dc, dl, wen, bad);
    n_tests++;
    if (dl !== el || dc !== ec || wen !== ew) begin
      n_fail++; $display("FAIL reset_clears_link: got load %h cyc %0d want %h %0d", dl, dc, el, ec);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    bit ld_bad = 1'b0;
    busy_cfg = 0; err_cfg = 1'b0;
    dREN = 1'b1; dWEN = 1'b0; datomic = 1'b0; daddr = 32'h20C;
    for (int c = 0; c <= 8; c++) begin
      if (dhit) begin
        hits.push_back(c);
        if (dload !== model_mem[131]) ld_bad = 1'b1;
      end
      if (c < 8) tick();
    end
    dREN = 1'b0;
    tick();
    n_tests++;
    if (hits.size() != 3 || hits[0] != 2 || hits[1] != 5 || hits[2] != 8 || ld_bad) begin
      n_fail++; $display("FAIL back_to_back: got %0d hits first %0d badload %0d want 3 hits at 2,5,8",
                         hits.size(), (hits.size() > 0) ? hits[0] : -1, ld_bad);
    end
  endtask

  task automatic test_random();
    int op, busy, ec, ew, cyc, wen, ic, ren, r;
    logic [31:0] a, d, el, ld, il, fa;
    bit err, bad;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 2) ? OpFetch : (r < 4) ? OpRead : (r < 6) ? OpWrite : (r == 6) ? OpLl :
           (r < 9) ? OpSc : OpRdWr;
      a = 32'h200 + 32'(4 * $urandom_range(0, 3));
      d = $urandom;
      busy = $urandom_range(0, 3);
      err = (op == OpFetch || op == OpRead) && ($urandom_range(0, 5) == 0);
      model_apply(op, a, d, busy, err, ec, el, ew);
      if (op == OpFetch) begin
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, a, '0, '0, busy, err, cyc, ic, ld, il, wen, ren, bad, fa);
      end else begin
        data_op(op, a, d, busy, err, cyc, ld, wen, bad);
      end
      n_tests++;
      if (cyc !== ec || ld !== el || wen !== ew || bad !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op %0d addr %h: got cyc %0d load %h wen %0d bad %0d want %0d %h %0d 0",
                 n, op, a, cyc, ld, wen, bad, ec, el, ew);
      end
    end
    for (int k = 0; k < 4; k++) begin
      a = 32'h200 + 32'(4 * k);
      n_tests++;
      if (ram_word(a) !== model_mem[a[9:2]]) begin
        n_fail++; $display("FAIL random_mem %h: got %h want %h", a, ram_word(a), model_mem[a[9:2]]);
      end
    end
  endtask

  initial begin
    seed = $urandom;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i, seed);
    test_reset();
    test_fetch();
    test_priority();
    test_busy_write();
    test_llsc();
    test_ll_store_sc();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
